// File: rtl/branch_predict_sel_pkg.sv
// -----------------------------------------------------------------------------
// branch_predict_sel_pkg
// Shared definitions for the branch predictor and the fetch-stage PC mux:
//   - pc_sel_e   : next-PC source encodings (0..4)
//   - CNT_*      : 2-bit saturating direction counter states
//   - cnt_next() : saturating counter step helper
// -----------------------------------------------------------------------------
package branch_predict_sel_pkg;

    typedef enum logic [2:0] {
        PC_ADD4        = 3'd0,
        PC_JALR        = 3'd1,
        PC_ALU_ANS     = 3'd2,
        PC_BRANCH_ADDR = 3'd3,
        PC_ADD4_EX     = 3'd4
    } pc_sel_e;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Counter value after reset and after allocating a fresh taken entry.
    localparam logic [1:0] CNT_RESET = CNT_WNT;
    localparam logic [1:0] CNT_ALLOC = CNT_WT;

    // Saturating step of a 2-bit direction counter.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end else begin
            nxt = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_sel_table.sv
// -----------------------------------------------------------------------------
// bp_table
// Direct-mapped BTB/BHT storage: valid, tag, target, 2-bit counter per entry.
//   clk, rst                 : clock, asynchronous active-high clear
//   rd_idx                   : async-read index (fetch lookup)
//   rd_valid/tag/target/cnt  : contents of the indexed entry (pre-update)
//   wr_en, wr_idx, wr_tag    : resolved conditional branch update request
//   wr_taken, wr_target      : resolved outcome and target
// An update to a matching entry steps the counter (and refreshes the target
// when taken); a miss allocates only when taken.
// -----------------------------------------------------------------------------
module bp_table
    import branch_predict_sel_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [XLEN-1:0]  rd_target,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic [XLEN-1:0]  wr_target
);

    logic [ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]   tag_r    [ENTRIES];
    logic [XLEN-1:0]    target_r [ENTRIES];
    logic [1:0]         cnt_r    [ENTRIES];
    logic               wr_hit_s;

    assign rd_valid  = valid_r[rd_idx];
    assign rd_tag    = tag_r[rd_idx];
    assign rd_target = target_r[rd_idx];
    assign rd_cnt    = cnt_r[rd_idx];

    assign wr_hit_s  = valid_r[wr_idx] & (tag_r[wr_idx] == wr_tag);

    // Table state: async clear, then hit-update or taken-miss allocation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {XLEN{1'b0}};
                cnt_r[i]    <= CNT_RESET;
            end
        end else if (wr_en) begin
            if (wr_hit_s) begin
                cnt_r[wr_idx] <= cnt_next(cnt_r[wr_idx], wr_taken);
                if (wr_taken) begin
                    target_r[wr_idx] <= wr_target;
                end
            end else if (wr_taken) begin
                valid_r[wr_idx]  <= 1'b1;
                tag_r[wr_idx]    <= wr_tag;
                target_r[wr_idx] <= wr_target;
                cnt_r[wr_idx]    <= CNT_ALLOC;
            end
        end
    end

endmodule

// File: rtl/branch_predict_sel.sv
// -----------------------------------------------------------------------------
// branch_predict_sel
// Fetch-stage branch prediction plus next-PC source selection.
//   clk, rst          : clock, asynchronous active-high reset
//   stall             : blocks table/counter updates and EX redirects
//   if_pc             : fetch PC for the combinational lookup
//   pred_taken/target : fetch prediction (target 0 when not taken)
//   ex_*              : resolved EX-stage instruction and its carried prediction
//   pc_sel            : next-PC source (see pc_sel_e)
//   control_hazard    : flush IF/ID on an EX redirect
//   mispredict_cnt    : saturating count of redirect cycles
// -----------------------------------------------------------------------------
module branch_predict_sel
    import branch_predict_sel_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    input  logic [1:0]       ex_pc_sel,
    output logic [2:0]       pc_sel,
    output logic             control_hazard,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [IDX_W-1:0] if_idx_s;
    logic [TAG_W-1:0] if_tag_s;
    logic             rd_valid_s;
    logic [TAG_W-1:0] rd_tag_s;
    logic [XLEN-1:0]  rd_target_s;
    logic [1:0]       rd_cnt_s;
    logic             hit_s;
    logic             ex_act_s;
    logic             br_wrong_s;
    logic             redirect_s;
    logic             any_redirect_s;
    logic             upd_en_s;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       unused_bits_s;

    // Byte-offset bits never reach the table.
    assign unused_bits_s = {if_pc[1:0], ex_pc[1:0]};

    assign if_idx_s = if_pc[IDX_W+1:2];
    assign if_tag_s = if_pc[XLEN-1:IDX_W+2];

    assign ex_act_s = ex_valid & ~stall;
    assign upd_en_s = ex_act_s & ex_branch;

    // Predicted taken but fell through: resume at the EX pc+4.
    assign br_wrong_s = ex_act_s & ex_branch & ex_pred_taken & ~ex_taken;
    // Actually taken but not predicted, or predicted to the wrong place.
    assign redirect_s = ex_act_s & (ex_jump | (ex_branch & ex_taken))
                      & (~ex_pred_taken | (ex_pred_target != ex_target));
    assign any_redirect_s = br_wrong_s | redirect_s;

    bp_table #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_bp_table (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (if_idx_s),
        .rd_valid  (rd_valid_s),
        .rd_tag    (rd_tag_s),
        .rd_target (rd_target_s),
        .rd_cnt    (rd_cnt_s),
        .wr_en     (upd_en_s),
        .wr_idx    (ex_pc[IDX_W+1:2]),
        .wr_tag    (ex_pc[XLEN-1:IDX_W+2]),
        .wr_taken  (ex_taken),
        .wr_target (ex_target)
    );

    // Lookup returns pre-update contents; no write-to-read bypass.
    assign hit_s       = rd_valid_s & (rd_tag_s == if_tag_s);
    assign pred_taken  = hit_s & rd_cnt_s[1];
    assign pred_target = pred_taken ? rd_target_s : {XLEN{1'b0}};

    // Next-PC source priority: EX corrections beat the fetch prediction.
    always_comb begin
        pc_sel         = PC_ADD4;
        control_hazard = 1'b0;
        if (br_wrong_s) begin
            pc_sel         = PC_ADD4_EX;
            control_hazard = 1'b1;
        end else if (redirect_s) begin
            pc_sel         = {1'b0, ex_pc_sel};
            control_hazard = 1'b1;
        end else if (pred_taken) begin
            pc_sel         = PC_BRANCH_ADDR;
            control_hazard = 1'b0;
        end else begin
            pc_sel         = PC_ADD4;
            control_hazard = 1'b0;
        end
    end

    // Saturating mispredict counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (any_redirect_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign mispredict_cnt = cnt_r;

endmodule

// File: tb/tb_branch_predict_sel.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_sel
// Directed scenarios followed by randomized traffic, both checked against a
// behavioural model of the predictor table and redirect rules. A second
// instance with a 2-bit mispredict counter shares all inputs to exercise
// counter saturation.
// -----------------------------------------------------------------------------
module tb_branch_predict_sel;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] if_pc;
    logic        ex_valid, ex_branch, ex_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic [1:0]  ex_pc_sel;

    logic        pred_taken, control_hazard;
    logic [31:0] pred_target;
    logic [2:0]  pc_sel;
    logic [15:0] mispredict_cnt;

    logic        pred_taken2, control_hazard2;
    logic [31:0] pred_target2;
    logic [2:0]  pc_sel2;
    logic [1:0]  mispredict_cnt2;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model: 16 direct-mapped entries, counter kept as 0..3.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [16];
    int          mc;
    bit          m_fire;

    always #5 clk = ~clk;

    branch_predict_sel #(.XLEN(32), .ENTRIES(16), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_pc_sel(ex_pc_sel), .pc_sel(pc_sel),
        .control_hazard(control_hazard), .mispredict_cnt(mispredict_cnt)
    );

    branch_predict_sel #(.XLEN(32), .ENTRIES(16), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc),
        .pred_taken(pred_taken2), .pred_target(pred_target2),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_pc_sel(ex_pc_sel), .pc_sel(pc_sel2),
        .control_hazard(control_hazard2), .mispredict_cnt(mispredict_cnt2)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd16);
    endfunction

    function automatic logic [31:0] mtag(input logic [31:0] pc);
        return pc / 32'd64;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'd0;
            m_tgt[i]   = 32'd0;
            m_cnt[i]   = 1;
        end
        mc = 0;
    endtask

    task automatic idle();
        stall          = 1'b0;
        ex_valid       = 1'b0;
        ex_branch      = 1'b0;
        ex_jump        = 1'b0;
        ex_taken       = 1'b0;
        ex_pred_taken  = 1'b0;
        ex_pc          = 32'd0;
        ex_target      = 32'd0;
        ex_pred_target = 32'd0;
        ex_pc_sel      = 2'd2;
    endtask

    task automatic set_ex(input bit br, input bit jmp, input bit tk, input logic [31:0] pc,
                          input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                          input logic [1:0] sel);
        ex_valid       = 1'b1;
        ex_branch      = br;
        ex_jump        = jmp;
        ex_taken       = tk;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
        ex_pc_sel      = sel;
    endtask

    // Wait to the falling edge and compare every output with the model.
    task automatic settle_check();
        int  i;
        bit  hit, ept, act, fa, fb;
        logic [31:0] etgt;
        int  epsel;
        @(negedge clk);
        i    = midx(if_pc);
        hit  = m_valid[i] && (m_tag[i] == mtag(if_pc));
        ept  = hit && (m_cnt[i] >= 2);
        etgt = ept ? m_tgt[i] : 32'd0;
        act  = ex_valid && !stall;
        fa   = act && ex_branch && ex_pred_taken && !ex_taken;
        fb   = act && (ex_jump || (ex_branch && ex_taken))
                   && (!ex_pred_taken || (ex_pred_target != ex_target));
        if (fa)          epsel = 4;
        else if (fb)     epsel = int'(ex_pc_sel);
        else if (ept)    epsel = 3;
        else             epsel = 0;
        m_fire = fa || fb;
        check_val("pred_taken",  64'(pred_taken),      64'(ept));
        check_val("pred_target", 64'(pred_target),     64'(etgt));
        check_val("pc_sel",      64'(pc_sel),          64'(epsel));
        check_val("hazard",      64'(control_hazard),  64'(m_fire));
        check_val("cnt16",       64'(mispredict_cnt),  64'(mc));
        check_val("cnt2",        64'(mispredict_cnt2), 64'((mc > 3) ? 3 : mc));
    endtask

    // Clock edge; advance the model with the inputs that were present.
    task automatic tick();
        int i;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (m_fire && mc < 65535) mc++;
            if (ex_valid && !stall && ex_branch) begin
                i = midx(ex_pc);
                if (m_valid[i] && m_tag[i] == mtag(ex_pc)) begin
                    m_cnt[i] = ex_taken ? ((m_cnt[i] == 3) ? 3 : m_cnt[i] + 1)
                                        : ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1);
                    if (ex_taken) m_tgt[i] = ex_target;
                end else if (ex_taken) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = mtag(ex_pc);
                    m_tgt[i]   = ex_target;
                    m_cnt[i]   = 2;
                end
            end
        end
        #1;
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0:       r = 32'h100;
            1:       r = 32'h140;
            2:       r = 32'h104;
            3:       r = 32'h3C0;
            4:       r = 32'h2000_0100;
            default: r = $urandom & 32'hFFFF_FFFC;
        endcase
        return r;
    endfunction

    initial begin
        model_clear();
        idle();
        rst   = 1'b1;
        if_pc = 32'h100;
        #1;
        check_val("rst_pred_taken", 64'(pred_taken), 64'd0);
        check_val("rst_pc_sel",     64'(pc_sel),     64'd0);
        check_val("rst_cnt",        64'(mispredict_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Unpredicted taken branch redirects and allocates.
        set_ex(1'b1, 1'b0, 1'b1, 32'h100, 32'h180, 1'b0, 32'h0, 2'd2);
        settle_check();
        check_val("d040_psel", 64'(pc_sel), 64'd2);
        check_val("d040_hz",   64'(control_hazard), 64'd1);
        tick();
        idle();
        settle_check();
        check_val("d040_cnt",  64'(mispredict_cnt), 64'd1);
        check_val("d040_pt",   64'(pred_taken), 64'd1);
        check_val("d040_tgt",  64'(pred_target), 64'h180);
        check_val("d040_psel3", 64'(pc_sel), 64'd3);
        tick();

        // Predicted taken but falls through: counter 10 -> 01.
        set_ex(1'b1, 1'b0, 1'b0, 32'h100, 32'h180, 1'b1, 32'h180, 2'd2);
        settle_check();
        check_val("d041_psel", 64'(pc_sel), 64'd4);
        check_val("d041_hz",   64'(control_hazard), 64'd1);
        tick();
        idle();
        settle_check();
        check_val("d041_pt", 64'(pred_taken), 64'd0);
        tick();

        // Aliasing: 0x140 shares the index and replaces 0x100.
        set_ex(1'b1, 1'b0, 1'b1, 32'h100, 32'h1A0, 1'b0, 32'h0, 2'd2);
        settle_check();
        tick();
        set_ex(1'b1, 1'b0, 1'b1, 32'h140, 32'h1C0, 1'b0, 32'h0, 2'd2);
        settle_check();
        tick();
        idle();
        settle_check();
        check_val("d042_miss", 64'(pred_taken), 64'd0);
        tick();
        if_pc = 32'h140;
        settle_check();
        check_val("d042_new", 64'(pred_taken), 64'd1);
        tick();

        // EX jump wins over a fetch hit; under stall the fetch prediction wins.
        set_ex(1'b0, 1'b1, 1'b1, 32'h400, 32'h500, 1'b0, 32'h0, 2'd1);
        settle_check();
        check_val("d043_psel", 64'(pc_sel), 64'd1);
        check_val("d043_hz",   64'(control_hazard), 64'd1);
        tick();
        stall = 1'b1;
        settle_check();
        check_val("d043_stall_psel", 64'(pc_sel), 64'd3);
        check_val("d043_stall_hz",   64'(control_hazard), 64'd0);
        tick();
        stall = 1'b0;

        // Four more redirects: the 2-bit counter must hold at 3.
        for (int k = 0; k < 4; k++) begin
            set_ex(1'b0, 1'b1, 1'b1, 32'h600, 32'h700 + 32'(k), 1'b0, 32'h0, 2'd2);
            settle_check();
            tick();
        end
        idle();
        settle_check();
        check_val("d044_sat", 64'(mispredict_cnt2), 64'd3);

        // Reset in the middle of an allocating update.
        set_ex(1'b1, 1'b0, 1'b1, 32'h300, 32'h380, 1'b0, 32'h0, 2'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("d044_rst_cnt",  64'(mispredict_cnt),  64'd0);
        check_val("d044_rst_cnt2", 64'(mispredict_cnt2), 64'd0);
        check_val("d044_rst_pt",   64'(pred_taken),      64'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        for (int k = 0; k < 16; k++) begin
            if_pc = (k < 4) ? ((k == 0) ? 32'h100 : (k == 1) ? 32'h140 : (k == 2) ? 32'h300 : 32'h400)
                            : 32'(k) * 32'd4;
            settle_check();
            tick();
        end

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            int kind;
            idle();
            if_pc = pick_pc();
            stall = ($urandom_range(0, 4) == 0);
            kind  = $urandom_range(0, 3);
            if (kind != 0) begin
                ex_valid       = ($urandom_range(0, 3) != 0);
                ex_branch      = (kind != 3);
                ex_jump        = (kind == 3);
                ex_taken       = ex_jump ? 1'b1 : 1'($urandom_range(0, 1));
                ex_pc          = pick_pc();
                ex_target      = ($urandom_range(0, 1) == 1) ? 32'h180 : ($urandom & 32'hFFFF_FFFC);
                ex_pred_taken  = 1'($urandom_range(0, 1));
                ex_pred_target = ($urandom_range(0, 2) != 0) ? ex_target : 32'h180;
                ex_pc_sel      = 2'($urandom_range(1, 2));
            end
            settle_check();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
